mat_mult: RTL and testbench

Sequential float32 matrix multiplier computing output_mat = input_a × input_b, where input_a is MxN and input_b is NxP.
It is the dense-layer stage directly upstream of mat_sigmoid, and its output_mat/stb/ack port set connects directly to mat_sigmoid's input_mat/stb/ack.
It time-multiplexes one `multiplier` instance and one `adder` instance from the float library.
Both instances use stb/ack handshakes with ports input_a, input_b, output_z, each with its _stb and _ack.

---
 rtl/mat_mult.sv | 398 +++++++++++++++++++++++++++++++++++++++
 tb/tb_mat_mult.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult.sv
// Sequential float32 matrix multiplier (output_mat = input_a x input_b) that time-shares
// one multiplier and one adder, together with the round-to-nearest-even float units it uses.

package mat_mult_fp_pkg;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Subnormal operands and results are flushed to signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [47:0]        prod;
        logic [23:0]        mant;
        logic [24:0]        mr;
        logic               g;
        logic               st;
        logic signed [10:0] e;
        logic [31:0]        r;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) begin
            r = QNAN;
        end else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            r = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? QNAN : {s, 8'hFF, 23'd0};
        end else if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            r = {s, 31'd0};
        end else begin
            prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
            e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
            if (prod[47]) begin
                mant = prod[47:24];
                g    = prod[23];
                st   = |prod[22:0];
                e    = e + 11'sd1;
            end else begin
                mant = prod[46:23];
                g    = prod[22];
                st   = |prod[21:0];
            end
            mr = {1'b0, mant} + {24'd0, g && (st || mant[0])};
            if (mr[24]) begin
                mr = mr >> 1;
                e  = e + 11'sd1;
            end
            if (e >= 11'sd255)     r = {s, 8'hFF, 23'd0};
            else if (e <= 11'sd0)  r = {s, 31'd0};
            else                   r = {s, e[7:0], mr[22:0]};
        end
        return r;
    endfunction

    // Mantissas carry guard/round/sticky bits; the aligned operand folds lost bits into sticky.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        big;
        logic [31:0]        sml;
        logic [7:0]         d;
        logic [26:0]        mb;
        logic [26:0]        ms;
        logic [53:0]        sh;
        logic [27:0]        s;
        logic [24:0]        mr;
        logic signed [10:0] e;
        logic [31:0]        r;
        if (is_nan(a) || is_nan(b)) begin
            r = QNAN;
        end else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) begin
            r = (a[31] != b[31]) ? QNAN : a;
        end else if (a[30:23] == 8'hFF) begin
            r = a;
        end else if (b[30:23] == 8'hFF) begin
            r = b;
        end else if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
            r = {a[31] & b[31], 31'd0};
        end else if (a[30:23] == 8'd0) begin
            r = b;
        end else if (b[30:23] == 8'd0) begin
            r = a;
        end else begin
            if (a[30:0] >= b[30:0]) begin
                big = a;
                sml = b;
            end else begin
                big = b;
                sml = a;
            end
            d  = big[30:23] - sml[30:23];
            d  = (d > 8'd30) ? 8'd30 : d;
            mb = {1'b1, big[22:0], 3'b000};
            ms = {1'b1, sml[22:0], 3'b000};
            sh = {ms, 27'd0} >> d;
            ms = sh[53:27] | {26'd0, |sh[26:0]};
            e  = $signed({3'b000, big[30:23]});
            if (big[31] == sml[31]) s = {1'b0, mb} + {1'b0, ms};
            else                    s = {1'b0, mb} - {1'b0, ms};
            if (s == 28'd0) begin
                r = 32'd0;
            end else begin
                if (s[27]) begin
                    s = {1'b0, s[27:2], s[1] | s[0]};
                    e = e + 11'sd1;
                end else begin
                    for (int n = 0; n < 26; n++) begin
                        if (!s[26]) begin
                            s = s << 1;
                            e = e - 11'sd1;
                        end
                    end
                end
                mr = {1'b0, s[26:3]} + {24'd0, s[2] && ((|s[1:0]) || s[3])};
                if (mr[24]) begin
                    mr = mr >> 1;
                    e  = e + 11'sd1;
                end
                if (e >= 11'sd255)     r = {big[31], 8'hFF, 23'd0};
                else if (e <= 11'sd0)  r = {big[31], 31'd0};
                else                   r = {big[31], e[7:0], mr[22:0]};
            end
        end
        return r;
    endfunction
endpackage

module fp_unit #(
    parameter bit IS_ADD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    import mat_mult_fp_pkg::*;

    logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic        have_a_q, have_a_d, have_b_q, have_b_d;
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

    // Operand, result and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= 32'd0;  b_q <= 32'd0;  z_q <= 32'd0;
            have_a_q <= 1'b0;  have_b_q <= 1'b0;
            a_ack_q  <= 1'b0;  b_ack_q  <= 1'b0;  z_stb_q <= 1'b0;
        end else begin
            a_q <= a_d;  b_q <= b_d;  z_q <= z_d;
            have_a_q <= have_a_d;  have_b_q <= have_b_d;
            a_ack_q  <= a_ack_d;   b_ack_q  <= b_ack_d;   z_stb_q <= z_stb_d;
        end
    end

    // Collect each operand independently, compute once both are held, then offer the result.
    always_comb begin
        a_d = a_q;  b_d = b_q;  z_d = z_q;
        have_a_d = have_a_q;  have_b_d = have_b_q;
        a_ack_d  = a_ack_q;   b_ack_d  = b_ack_q;   z_stb_d = z_stb_q;
        if (z_stb_q) begin
            if (output_z_ack) z_stb_d = 1'b0;
            else              z_stb_d = 1'b1;
        end else if (have_a_q && have_b_q) begin
            z_d      = IS_ADD ? fp_add(a_q, b_q) : fp_mul(a_q, b_q);
            z_stb_d  = 1'b1;
            have_a_d = 1'b0;
            have_b_d = 1'b0;
        end else begin
            if (a_ack_q && input_a_stb) begin
                a_d = input_a;  have_a_d = 1'b1;  a_ack_d = 1'b0;
            end else begin
                a_ack_d = !have_a_q;
            end
            if (b_ack_q && input_b_stb) begin
                b_d = input_b;  have_b_d = 1'b1;  b_ack_d = 1'b0;
            end else begin
                b_ack_d = !have_b_q;
            end
        end
    end

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;
endmodule

module multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    fp_unit #(.IS_ADD(1'b0)) u_core (.*);
endmodule

module adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    fp_unit #(.IS_ADD(1'b1)) u_core (.*);
endmodule

module mat_mult #(
    parameter int M = 1,
    parameter int N = 1,
    parameter int P = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [M-1:0][N-1:0][31:0]   input_a,
    input  logic [N-1:0][P-1:0][31:0]   input_b,
    input  logic                        input_mat_stb,
    output logic                        input_mat_ack,
    output logic [M-1:0][P-1:0][31:0]   output_mat,
    output logic                        output_mat_stb,
    input  logic                        output_mat_ack
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int JW = (P > 1) ? $clog2(P) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [JW-1:0] J_LAST = JW'(P - 1);

    typedef enum logic [2:0] {GET_MAT, MUL_IN, MUL_OUT, ADD_IN, ADD_OUT, PUT_MAT} state_t;

    state_t                      state_q, state_d;
    logic [M-1:0][N-1:0][31:0]   a_mat_q, a_mat_d;
    logic [N-1:0][P-1:0][31:0]   b_mat_q, b_mat_d;
    logic [M-1:0][P-1:0][31:0]   c_mat_q, c_mat_d, out_mat_q, out_mat_d;
    logic [IW-1:0]               i_q, i_d;
    logic [JW-1:0]               j_q, j_d;
    logic [KW-1:0]               k_q, k_d;
    logic [31:0]                 acc_q, acc_d, prod_q, prod_d;
    logic                        in_ack_q, in_ack_d, out_stb_q, out_stb_d;
    logic                        mul_a_stb_q, mul_a_stb_d, mul_b_stb_q, mul_b_stb_d, mul_z_ack_q, mul_z_ack_d;
    logic                        add_a_stb_q, add_a_stb_d, add_b_stb_q, add_b_stb_d, add_z_ack_q, add_z_ack_d;
    logic                        a_done_q, a_done_d, b_done_q, b_done_d;
    logic                        mul_a_ack_s, mul_b_ack_s, mul_z_stb_s, add_a_ack_s, add_b_ack_s, add_z_stb_s;
    logic [31:0]                 mul_z_s, add_z_s;

    multiplier u_mul (
        .clk(clk), .rst(rst),
        .input_a(a_mat_q[i_q][k_q]), .input_a_stb(mul_a_stb_q), .input_a_ack(mul_a_ack_s),
        .input_b(b_mat_q[k_q][j_q]), .input_b_stb(mul_b_stb_q), .input_b_ack(mul_b_ack_s),
        .output_z(mul_z_s), .output_z_stb(mul_z_stb_s), .output_z_ack(mul_z_ack_q)
    );

    adder u_add (
        .clk(clk), .rst(rst),
        .input_a(acc_q), .input_a_stb(add_a_stb_q), .input_a_ack(add_a_ack_s),
        .input_b(prod_q), .input_b_stb(add_b_stb_q), .input_b_ack(add_b_ack_s),
        .output_z(add_z_s), .output_z_stb(add_z_stb_s), .output_z_ack(add_z_ack_q)
    );

    // State, operand, index and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GET_MAT;
            a_mat_q <= '0;  b_mat_q <= '0;  c_mat_q <= '0;  out_mat_q <= '0;
            i_q <= IW'(0);  j_q <= JW'(0);  k_q <= KW'(0);
            acc_q <= 32'h0;  prod_q <= 32'h0;
            in_ack_q <= 1'b0;  out_stb_q <= 1'b0;
            mul_a_stb_q <= 1'b0;  mul_b_stb_q <= 1'b0;  mul_z_ack_q <= 1'b0;
            add_a_stb_q <= 1'b0;  add_b_stb_q <= 1'b0;  add_z_ack_q <= 1'b0;
            a_done_q <= 1'b0;  b_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_mat_q <= a_mat_d;  b_mat_q <= b_mat_d;  c_mat_q <= c_mat_d;  out_mat_q <= out_mat_d;
            i_q <= i_d;  j_q <= j_d;  k_q <= k_d;
            acc_q <= acc_d;  prod_q <= prod_d;
            in_ack_q <= in_ack_d;  out_stb_q <= out_stb_d;
            mul_a_stb_q <= mul_a_stb_d;  mul_b_stb_q <= mul_b_stb_d;  mul_z_ack_q <= mul_z_ack_d;
            add_a_stb_q <= add_a_stb_d;  add_b_stb_q <= add_b_stb_d;  add_z_ack_q <= add_z_ack_d;
            a_done_q <= a_done_d;  b_done_q <= b_done_d;
        end
    end

    // Next-state logic: one multiply-accumulate step per MUL_IN..ADD_OUT pass, k ascending.
    always_comb begin
        state_d = state_q;
        a_mat_d = a_mat_q;  b_mat_d = b_mat_q;  c_mat_d = c_mat_q;  out_mat_d = out_mat_q;
        i_d = i_q;  j_d = j_q;  k_d = k_q;
        acc_d = acc_q;  prod_d = prod_q;
        in_ack_d = in_ack_q;  out_stb_d = out_stb_q;
        mul_a_stb_d = mul_a_stb_q;  mul_b_stb_d = mul_b_stb_q;  mul_z_ack_d = mul_z_ack_q;
        add_a_stb_d = add_a_stb_q;  add_b_stb_d = add_b_stb_q;  add_z_ack_d = add_z_ack_q;
        a_done_d = a_done_q;  b_done_d = b_done_q;
        case (state_q)
            GET_MAT: begin
                if (in_ack_q && input_mat_stb) begin
                    a_mat_d  = input_a;
                    b_mat_d  = input_b;
                    in_ack_d = 1'b0;
                    i_d = IW'(0);  j_d = JW'(0);  k_d = KW'(0);
                    acc_d   = 32'h0;
                    state_d = MUL_IN;
                end else begin
                    in_ack_d = 1'b1;
                end
            end
            MUL_IN: begin
                if (a_done_q && b_done_q) begin
                    a_done_d = 1'b0;  b_done_d = 1'b0;  state_d = MUL_OUT;
                end else begin
                    if (a_done_q)                             mul_a_stb_d = 1'b0;
                    else if (mul_a_stb_q && mul_a_ack_s) begin mul_a_stb_d = 1'b0;  a_done_d = 1'b1; end
                    else                                      mul_a_stb_d = 1'b1;
                    if (b_done_q)                             mul_b_stb_d = 1'b0;
                    else if (mul_b_stb_q && mul_b_ack_s) begin mul_b_stb_d = 1'b0;  b_done_d = 1'b1; end
                    else                                      mul_b_stb_d = 1'b1;
                end
            end
            MUL_OUT: begin
                if (mul_z_ack_q && mul_z_stb_s) begin
                    prod_d = mul_z_s;  mul_z_ack_d = 1'b0;  state_d = ADD_IN;
                end else begin
                    mul_z_ack_d = 1'b1;
                end
            end
            ADD_IN: begin
                if (a_done_q && b_done_q) begin
                    a_done_d = 1'b0;  b_done_d = 1'b0;  state_d = ADD_OUT;
                end else begin
                    if (a_done_q)                             add_a_stb_d = 1'b0;
                    else if (add_a_stb_q && add_a_ack_s) begin add_a_stb_d = 1'b0;  a_done_d = 1'b1; end
                    else                                      add_a_stb_d = 1'b1;
                    if (b_done_q)                             add_b_stb_d = 1'b0;
                    else if (add_b_stb_q && add_b_ack_s) begin add_b_stb_d = 1'b0;  b_done_d = 1'b1; end
                    else                                      add_b_stb_d = 1'b1;
                end
            end
            ADD_OUT: begin
                if (add_z_ack_q && add_z_stb_s) begin
                    add_z_ack_d = 1'b0;
                    state_d     = MUL_IN;
                    if (k_q != K_LAST) begin
                        acc_d = add_z_s;
                        k_d   = k_q + KW'(1);
                    end else begin
                        c_mat_d[i_q][j_q] = add_z_s;
                        acc_d = 32'h0;
                        k_d   = KW'(0);
                        if (j_q != J_LAST) begin
                            j_d = j_q + JW'(1);
                        end else begin
                            j_d = JW'(0);
                            if (i_q != I_LAST) begin
                                i_d = i_q + IW'(1);
                            end else begin
                                i_d     = IW'(0);
                                state_d = PUT_MAT;
                            end
                        end
                    end
                end else begin
                    add_z_ack_d = 1'b1;
                end
            end
            PUT_MAT: begin
                if (out_stb_q && output_mat_ack) begin
                    out_stb_d = 1'b0;
                    state_d   = GET_MAT;
                end else begin
                    out_stb_d = 1'b1;
                    out_mat_d = c_mat_q;
                end
            end
            default: begin
                state_d = GET_MAT;
            end
        endcase
    end

    assign input_mat_ack  = in_ack_q;
    assign output_mat     = out_mat_q;
    assign output_mat_stb = out_stb_q;
endmodule

// File: tb/tb_mat_mult.sv
// Self-checking bench for mat_mult: a 2x2x2 instance and a 1x3x1 dot-product instance,
// checked against an exact fixed-point reference model converted to float32.
module tb_mat_mult;
    typedef logic [1:0][1:0][31:0] m22_t;
    typedef logic [0:0][2:0][31:0] a13_t;
    typedef logic [2:0][0:0][31:0] b31_t;

    logic clk = 1'b0;
    logic rst;
    m22_t a2, b2, c2;
    logic stb2, iack2, ostb2, oack2;
    a13_t a3;
    b31_t b3;
    logic [0:0][0:0][31:0] c3;
    logic stb3, iack3, ostb3, oack3;
    int   n_cmp = 0;
    int   n_err = 0;
    m22_t ta, tb, tc, ua, ub, uc, id_a, id_b, id_c, lit;
    int   qa[2][2];
    int   qb[2][2];

    always #5 clk = ~clk;

    mat_mult #(.M(2), .N(2), .P(2)) u_dut (
        .clk(clk), .rst(rst), .input_a(a2), .input_b(b2),
        .input_mat_stb(stb2), .input_mat_ack(iack2),
        .output_mat(c2), .output_mat_stb(ostb2), .output_mat_ack(oack2)
    );

    mat_mult #(.M(1), .N(3), .P(1)) u_dot (
        .clk(clk), .rst(rst), .input_a(a3), .input_b(b3),
        .input_mat_stb(stb3), .input_mat_ack(iack3),
        .output_mat(c3), .output_mat_stb(ostb3), .output_mat_ack(oack3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    // Exact float32 encoding of v / 2**fb (|v| < 2**24).
    function automatic logic [31:0] fx_to_fp(input int v, input int fb);
        int          mag;
        int          p;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int t = 0; t < 31; t++) if ((mag >> t) != 0) p = t;
        m = 32'(mag) << (23 - p);
        return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + p - fb), m[22:0]};
    endfunction

    // Operands are quarters, so every product sum is exact in sixteenths.
    task automatic build2(input int xa[2][2], input int xb[2][2], output m22_t pa, output m22_t pb, output m22_t pc);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 2; k++) s += xa[i][k] * xb[k][j];
                pa[i][j] = fx_to_fp(xa[i][j], 2);
                pb[i][j] = fx_to_fp(xb[i][j], 2);
                pc[i][j] = fx_to_fp(s, 4);
            end
        end
    endtask

    task automatic rand2(output m22_t pa, output m22_t pb, output m22_t pc);
        int xa[2][2];
        int xb[2][2];
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                xa[i][j] = int'($urandom_range(64, 0)) - 32;
                xb[i][j] = int'($urandom_range(64, 0)) - 32;
            end
        end
        build2(xa, xb, pa, pb, pc);
    endtask

    task automatic send2(input m22_t a, input m22_t b, input bit keep_stb);
        int t;
        t = 0;
        a2 = a;  b2 = b;  stb2 = 1'b1;
        while (!iack2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_ack_wait", 32'(t < 200), 32'd1);
        @(negedge clk);
        if (!keep_stb) stb2 = 1'b0;
    endtask

    task automatic recv2(input m22_t want, input int hold, input string tag);
        int t;
        int busy;
        int bad;
        t = 0;  busy = 0;  bad = 0;
        while (!ostb2 && t < 3000) begin
            if (iack2) busy++;
            @(negedge clk);
            t++;
        end
        chk({tag, "_stb"}, 32'(ostb2), 32'd1);
        chk({tag, "_busy_ack"}, 32'(busy), 32'd0);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                chk($sformatf("%s_c%0d%0d", tag, i, j), c2[i][j], want[i][j]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (c2 !== want || ostb2 !== 1'b1 || iack2 !== 1'b0) bad++;
        end
        if (hold > 0) chk({tag, "_hold"}, 32'(bad), 32'd0);
        oack2 = 1'b1;
        @(negedge clk);
        oack2 = 1'b0;
        chk({tag, "_stb_drop"}, 32'(ostb2), 32'd0);
        @(negedge clk);
        chk({tag, "_ack_rise"}, 32'(iack2), 32'd1);
    endtask

    task automatic run3(input int xa[3], input int xb[3], input string tag);
        int          t;
        int          s;
        a13_t        pa;
        b31_t        pb;
        s = 0;
        for (int k = 0; k < 3; k++) begin
            pa[0][k] = fx_to_fp(xa[k], 2);
            pb[k][0] = fx_to_fp(xb[k], 2);
            s += xa[k] * xb[k];
        end
        a3 = pa;  b3 = pb;  stb3 = 1'b1;
        t = 0;
        while (!iack3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        stb3 = 1'b0;
        t = 0;
        while (!ostb3 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_stb"}, 32'(ostb3), 32'd1);
        chk({tag, "_z"}, c3[0][0], fx_to_fp(s, 4));
        oack3 = 1'b1;
        @(negedge clk);
        oack3 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int da[3];
        int db[3];
        int t;
        rst = 1'b1;
        a2 = '0;  b2 = '0;  stb2 = 1'b0;  oack2 = 1'b0;
        a3 = '0;  b3 = '0;  stb3 = 1'b0;  oack3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_stb", 32'(ostb2), 32'd0);
        chk("rst_in_ack", 32'(iack2), 32'd0);
        chk("rst_out_mat", c2[1][1], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_in_ack", 32'(iack2), 32'd1);

        // 2x2 squares with 20 cycles of output backpressure
        qa = '{'{4, 8}, '{12, 16}};
        build2(qa, qa, ta, tb, tc);
        lit[0][0] = 32'h40E0_0000;  lit[0][1] = 32'h4120_0000;
        lit[1][0] = 32'h4170_0000;  lit[1][1] = 32'h41B0_0000;
        send2(ta, tb, 1'b0);
        recv2(lit, 20, "sq");

        // identity times B reproduces B
        qb = '{'{4, 0}, '{0, 4}};
        build2(qb, qa, id_a, id_b, id_c);
        send2(id_a, id_b, 1'b0);
        recv2(id_b, 0, "ident");

        // back-to-back with input_mat_stb held high through the first computation
        rand2(ta, tb, tc);
        rand2(ua, ub, uc);
        send2(ta, tb, 1'b1);
        a2 = ua;  b2 = ub;
        recv2(tc, 0, "b2b0");
        send2(ua, ub, 1'b0);
        recv2(uc, 0, "b2b1");

        // random operands; odd passes hold output_mat_ack high during compute
        for (int n = 0; n < 6; n++) begin
            rand2(ta, tb, tc);
            send2(ta, tb, 1'b0);
            if (n % 2 == 1) oack2 = 1'b1;
            recv2(tc, 0, $sformatf("rnd%0d", n));
        end

        // reset during the multiply phase, then a clean identity run
        send2(id_a, id_b, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_stb", 32'(ostb2), 32'd0);
        chk("rst_mid_ack", 32'(iack2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send2(id_a, id_b, 1'b0);
        recv2(id_b, 0, "post_rst");

        // reset while a result is being offered clears it at once
        rand2(ta, tb, tc);
        send2(ta, tb, 1'b0);
        t = 0;
        while (!ostb2 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("put_stb", 32'(ostb2), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_put_stb", 32'(ostb2), 32'd0);
        chk("rst_put_mat", c2[0][0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // dot products on the 1x3x1 instance
        da = '{4, 8, 12};
        db = '{16, 20, 24};
        run3(da, db, "dot_dir");
        chk("dot_dir_lit", c3[0][0], 32'h4200_0000);
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 3; k++) begin
                da[k] = int'($urandom_range(64, 0)) - 32;
                db[k] = int'($urandom_range(64, 0)) - 32;
            end
            run3(da, db, $sformatf("dot%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
